// File: rtl/pls_cnt_mod_if.sv
// ---------------------------------------------------------------------------
// pls_cnt_mod_if
// Signal bundle for the pulse counter pls_cnt_mod.
//
// Members (direction seen from the counter, i.e. the slave modport):
//   clr    in   asynchronous clear request, acts on its rising edge
//   plsi   in   asynchronous count pulse
//   dn     in   asynchronous direction level, 0 = up, 1 = down
//   en     in   count enable, already in the clk domain
//   ld     in   asynchronous load request, acts on its rising edge
//   ld_val in   load value (W bits), held stable while ld is high
//   qout   out  registered count value (W bits)
//   plso   out  one-cycle carry pulse on up wrap
//   bro    out  one-cycle borrow pulse on down wrap
//   tc     out  terminal count level
// The master modport is the side that drives the requests (the host / bench).
// ---------------------------------------------------------------------------
interface pls_cnt_mod_if #(
    parameter int W = 6
) ();
    logic         clr;
    logic         plsi;
    logic         dn;
    logic         en;
    logic         ld;
    logic [W-1:0] ld_val;
    logic [W-1:0] qout;
    logic         plso;
    logic         bro;
    logic         tc;

    modport master (
        output clr, plsi, dn, en, ld, ld_val,
        input  qout, plso, bro, tc
    );

    modport slave (
        input  clr, plsi, dn, en, ld, ld_val,
        output qout, plso, bro, tc
    );
endinterface

// File: rtl/pls_cnt_mod.sv
// ---------------------------------------------------------------------------
// pls_cnt_mod
// Modulo up/down counter clocked by an asynchronous pulse input.
// plsi, clr, ld and dn are brought into the clk domain with two-flop
// synchronizers; plsi, clr and ld get a third flop so their edges can be
// detected. A detected event changes qout on the third clk edge after the
// input change is first sampled.
//
// The count wraps within 0 .. modulus-1. The output width must hold the top
// value, and the edge-select parameter picks falling (0) or rising (1) plsi
// edges. All requests and results travel on the slave side of
// pls_cnt_mod_if; rst clears every flop asynchronously.
//
// Per-edge priority is clr > ld > count; a losing event is dropped.
// ---------------------------------------------------------------------------
module pls_cnt_mod #(
    parameter int MOD  = 10,
    parameter int W    = 6,
    parameter int EDGE = 0
) (
    input  logic          clk,
    input  logic          rst,
    pls_cnt_mod_if.slave  bus
);

    generate
        if (MOD < 2 || (64'd1 << W) < 64'(MOD) || EDGE < 0 || EDGE > 1) begin : g_param_err
            $error("pls_cnt_mod: need MOD >= 2, 2**W >= MOD and EDGE in {0,1}");
        end
    endgenerate

    localparam logic [W-1:0] MAXV = W'(MOD - 1);

    // Out-of-range load values saturate to the top of the count range.
    function automatic logic [W-1:0] clamp_ld(input logic [W-1:0] v);
        return ({1'b0, v} < (W+1)'(MOD)) ? v : MAXV;
    endfunction

    // Synchronizer / edge-detect chains: s1, s2 synchronize, s3 is the
    // previous synchronized level used for edge detection.
    logic         r_clr_s1, r_clr_s2, r_clr_s3;
    logic         r_ld_s1,  r_ld_s2,  r_ld_s3;
    logic         r_pls_s1, r_pls_s2, r_pls_s3;
    logic         r_dn_s1,  r_dn_s2;
    logic [W-1:0] r_q;
    logic         r_plso;
    logic         r_bro;

    logic w_clr_evt;
    logic w_ld_evt;
    logic w_pls_edge;
    logic w_cnt_evt;
    logic w_dn;

    assign w_clr_evt  = r_clr_s2 & ~r_clr_s3;
    assign w_ld_evt   = r_ld_s2  & ~r_ld_s3;
    assign w_pls_edge = (EDGE != 0) ? (r_pls_s2 & ~r_pls_s3) : (~r_pls_s2 & r_pls_s3);
    assign w_cnt_evt  = w_pls_edge & bus.en;
    assign w_dn       = r_dn_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_s1 <= 1'b0;
            r_clr_s2 <= 1'b0;
            r_clr_s3 <= 1'b0;
            r_ld_s1  <= 1'b0;
            r_ld_s2  <= 1'b0;
            r_ld_s3  <= 1'b0;
            r_pls_s1 <= 1'b0;
            r_pls_s2 <= 1'b0;
            r_pls_s3 <= 1'b0;
            r_dn_s1  <= 1'b0;
            r_dn_s2  <= 1'b0;
            r_q      <= '0;
            r_plso   <= 1'b0;
            r_bro    <= 1'b0;
        end else begin
            // synchronizer stage
            r_clr_s1 <= bus.clr;
            r_clr_s2 <= r_clr_s1;
            r_clr_s3 <= r_clr_s2;
            r_ld_s1  <= bus.ld;
            r_ld_s2  <= r_ld_s1;
            r_ld_s3  <= r_ld_s2;
            r_pls_s1 <= bus.plsi;
            r_pls_s2 <= r_pls_s1;
            r_pls_s3 <= r_pls_s2;
            r_dn_s1  <= bus.dn;
            r_dn_s2  <= r_dn_s1;

            // counter update stage
            r_plso <= 1'b0;
            r_bro  <= 1'b0;
            if (w_clr_evt) begin
                r_q      <= '0;
                // Collapse the plsi chain onto the newest sample so an edge
                // already in flight is not counted after the clear.
                r_pls_s2 <= r_pls_s1;
                r_pls_s3 <= r_pls_s1;
            end else if (w_ld_evt) begin
                r_q <= clamp_ld(bus.ld_val);
            end else if (w_cnt_evt) begin
                if (!w_dn) begin
                    if (r_q == MAXV) begin
                        r_q    <= '0;
                        r_plso <= 1'b1;
                    end else begin
                        r_q <= r_q + W'(1);
                    end
                end else begin
                    if (r_q == '0) begin
                        r_q   <= MAXV;
                        r_bro <= 1'b1;
                    end else begin
                        r_q <= r_q - W'(1);
                    end
                end
            end
        end
    end

    assign bus.qout = r_q;
    assign bus.plso = r_plso;
    assign bus.bro  = r_bro;
    // Terminal count follows the synchronized direction, not the raw pin.
    assign bus.tc   = w_dn ? (r_q == '0) : (r_q == MAXV);

endmodule
